// File: rtl/gate_sweep_bist.sv
// Configurable N-input logic gate with registered output and a truth-table sweep
// engine that checks the gate against an independent reduction-based golden model.
module gate_sweep_bist #(
    parameter int WIDTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_in_vec,
    input  logic             i_start,
    input  logic             i_fault_en,
    output logic             o_out,
    output logic [WIDTH-1:0] o_cur_vec,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_bad_mode
);
    // state   | meaning
    // S_IDLE  | gate follows i_in_vec and live i_mode; waits for i_start
    // S_SWEEP | applies sweep vector, compares previous vector's out/golden pair
    // S_DRAIN | applies all-ones, compares the last vector's pair
    // S_DONE  | publishes pass, done pulses on the following edge
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    localparam logic [WIDTH-1:0] ONES      = '1;
    localparam logic [WIDTH:0]   SWEEP_ONE = (WIDTH+1)'(1);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH:0]   r_sweep_vec;
    logic [WIDTH:0]   w_sweep_inc;
    logic [2:0]       r_mode_lat;
    logic [2:0]       w_mode_eff;
    logic [WIDTH-1:0] w_vec;
    logic             w_busy;
    logic             w_compare;
    logic             w_parity;
    logic             w_gate;
    logic             w_gold;
    logic             r_gold;
    logic             w_mismatch;

    assign w_sweep_inc = r_sweep_vec + SWEEP_ONE;
    assign w_mismatch  = (o_out != r_gold);
    assign o_busy      = w_busy;
    assign o_cur_vec   = w_vec;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_SWEEP;
            S_SWEEP: if (w_sweep_inc[WIDTH]) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = 1'b1;
        w_compare  = 1'b0;
        w_mode_eff = r_mode_lat;
        w_vec      = ONES;
        case (r_state)
            S_IDLE: begin
                w_busy     = 1'b0;
                w_mode_eff = i_mode;
                w_vec      = i_in_vec;
            end
            S_SWEEP: begin
                w_vec     = r_sweep_vec[WIDTH-1:0];
                w_compare = (r_sweep_vec != '0);
            end
            S_DRAIN: w_compare = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_parity = 1'b0;
        for (int i = 0; i < WIDTH; i++) w_parity = w_parity ^ w_vec[i];
    end

    // Gate built from equality/parity terms so it shares no structure with the golden.
    always_comb begin
        w_gate = 1'b0;
        case (w_mode_eff)
            3'd0:    w_gate = (w_vec == ONES);
            3'd1:    w_gate = (w_vec != '0);
            3'd2:    w_gate = (w_vec != ONES);
            3'd3:    w_gate = (w_vec == '0);
            3'd4:    w_gate = w_parity;
            3'd5:    w_gate = ~w_parity;
            default: w_gate = 1'b0;
        endcase
    end

    always_comb begin
        w_gold = 1'b0;
        case (w_mode_eff)
            3'd0:    w_gold = &w_vec;
            3'd1:    w_gold = |w_vec;
            3'd2:    w_gold = ~&w_vec;
            3'd3:    w_gold = ~|w_vec;
            3'd4:    w_gold = ^w_vec;
            3'd5:    w_gold = ~^w_vec;
            default: w_gold = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_out       <= 1'b0;
            r_gold      <= 1'b0;
            o_bad_mode  <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_err_cnt   <= '0;
            r_mode_lat  <= 3'd0;
            r_sweep_vec <= '0;
        end else begin
            o_out      <= w_gate ^ (i_fault_en & (w_vec == ONES));
            r_gold     <= w_gold;
            o_bad_mode <= w_mode_eff[2] & w_mode_eff[1];
            o_done     <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        o_err_cnt   <= '0;
                        o_pass      <= 1'b0;
                        r_mode_lat  <= i_mode;
                        r_sweep_vec <= '0;
                    end
                end
                S_SWEEP: r_sweep_vec <= w_sweep_inc;
                S_DONE:  o_pass <= (o_err_cnt == '0);
                default: ;
            endcase
            if (w_compare && w_mismatch && (o_err_cnt != ERR_MAX))
                o_err_cnt <= o_err_cnt + ERR_ONE;
        end
    end
endmodule
